// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define MULDIV_DIV_EN to compile the restoring divider; otherwise divide ops only pulse Done.
module muldiv_unit (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HiWrite,
  input  logic        LoWrite,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} state_t;

  state_t      state, state_next;
  logic [4:0]  cnt;
  logic [63:0] acc, acc_step;
  logic [31:0] opnd;
  logic        neg_q;

  logic        idle, launch;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_next, prod;
  logic [31:0] res_hi, res_lo, hi_next, lo_next;
  logic        busy_next, done_next;

  // Op[0]=0 selects the signed variants (MULT, DIV).
  assign a_neg = ~Op[0] & A[31];
  assign b_neg = ~Op[0] & B[31];
  assign a_mag = a_neg ? (~A + 32'd1) : A;
  assign b_mag = b_neg ? (~B + 32'd1) : B;
  assign idle  = (state == IDLE);

  // Shift-add: multiplier sits in acc[31:0] and drains out the bottom as the product fills in.
  assign mul_sum  = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mul_next = {mul_sum, acc[31:1]};
  assign prod     = neg_q ? (~acc + 64'd1) : acc;

`ifdef MULDIV_DIV_EN
  logic        is_div, neg_r, div_zero;
  logic [32:0] div_part, div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  logic [31:0] quot, rem;

  assign launch = idle & Start;

  // Restoring step: partial remainder in acc[63:32], dividend bits shift up, quotient bits enter at bit 0.
  assign div_part = acc[63:31];
  assign div_diff = div_part - {1'b0, opnd};
  assign div_ge   = (div_part >= {1'b0, opnd});
  assign div_next = div_ge ? {div_diff[31:0], acc[30:0], 1'b1}
                           : {div_part[31:0], acc[30:0], 1'b0};
  assign acc_step = is_div ? div_next : mul_next;

  assign quot   = acc[31:0];
  assign rem    = acc[63:32];
  // A zero divisor yields an all-ones quotient and leaves the dividend as remainder; only Lo needs forcing.
  assign res_lo = is_div ? (div_zero ? 32'hFFFF_FFFF : (neg_q ? (~quot + 32'd1) : quot))
                         : prod[31:0];
  assign res_hi = is_div ? (neg_r ? (~rem + 32'd1) : rem) : prod[63:32];
`else
  assign launch   = idle & Start & ~Op[1];
  assign acc_step = mul_next;
  assign res_lo   = prod[31:0];
  assign res_hi   = prod[63:32];
`endif

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch) state_next = CALC;
      CALC:    if (cnt == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    hi_next   = Hi;
    lo_next   = Lo;
    done_next = 1'b0;
    busy_next = (state_next != IDLE);
    if (state == FIX) begin
      hi_next   = res_hi;
      lo_next   = res_lo;
      done_next = 1'b1;
    end else if (idle && !Start) begin
      if (HiWrite) hi_next = A;
      if (LoWrite) lo_next = A;
    end
`ifndef MULDIV_DIV_EN
    if (idle && Start && Op[1]) done_next = 1'b1;
`endif
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Hi   <= 32'd0;
      Lo   <= 32'd0;
      Busy <= 1'b0;
      Done <= 1'b0;
    end else begin
      Hi   <= hi_next;
      Lo   <= lo_next;
      Busy <= busy_next;
      Done <= done_next;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt   <= 5'd0;
      acc   <= 64'd0;
      opnd  <= 32'd0;
      neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div   <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else if (launch) begin
      cnt   <= 5'd0;
      neg_q <= a_neg ^ b_neg;
      acc   <= Op[1] ? {32'd0, a_mag} : {32'd0, b_mag};
      opnd  <= Op[1] ? b_mag : a_mag;
`ifdef MULDIV_DIV_EN
      is_div   <= Op[1];
      neg_r    <= a_neg;
      div_zero <= (B == 32'd0);
`endif
    end else if (state == CALC) begin
      acc <= acc_step;
      cnt <= cnt + 5'd1;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        HiWrite = 1'b0;
  logic        LoWrite = 1'b0;
  logic [31:0] Hi, Lo;
  logic        Busy, Done;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  always #5 Clk = ~Clk;

  muldiv_unit dut (
    .Clk(Clk), .Rst(Rst), .Start(Start), .Op(Op), .A(A), .B(B),
    .HiWrite(HiWrite), .LoWrite(LoWrite),
    .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic bit div_enabled();
`ifdef MULDIV_DIV_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Architectural result of one operation, from the ISA's arithmetic rules.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint      p;
    logic [63:0] up;
    int          sa, sb;
    hi = exp_hi;
    lo = exp_lo;
    sa = a;
    sb = b;
    case (op)
      2'd0: begin
        p  = longint'(sa) * longint'(sb);
        hi = p[63:32];
        lo = p[31:0];
      end
      2'd1: begin
        up = {32'd0, a} * {32'd0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      default: begin
        if (div_enabled()) begin
          if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
          end else if (op == 2'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'd0;
          end else if (op == 2'd2) begin
            lo = sa / sb;
            hi = sa % sb;
          end else begin
            lo = a / b;
            hi = a % b;
          end
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit with_write, input string tag);
    logic [31:0] nh, nl;
    int          done_cnt;
    bit          busy_ok, hold_ok;
    model(op, a, b, nh, nl);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    HiWrite = with_write; LoWrite = with_write;
    @(posedge Clk); #1;  // E0
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    A = $urandom; B = $urandom;
    if (op[1] && !div_enabled()) begin
      check({tag, "_nodiv_done"}, Done, 1);
      check({tag, "_nodiv_busy"}, Busy, 0);
      check({tag, "_nodiv_hilo"}, {Hi, Lo}, {exp_hi, exp_lo});
      @(posedge Clk); #1;
      check({tag, "_nodiv_done_end"}, Done, 0);
      return;
    end
    check({tag, "_busy_e0"}, Busy, 1);
    done_cnt = 0; busy_ok = 1; hold_ok = 1;
    for (int e = 1; e <= 32; e++) begin
      if (disturb && e == 10) begin
        Start = 1'b1; Op = 2'($urandom); LoWrite = 1'b1; HiWrite = 1'b1;
      end
      @(posedge Clk); #1;
      Start = 1'b0; LoWrite = 1'b0; HiWrite = 1'b0;
      if (Done) done_cnt++;
      if (!Busy) busy_ok = 0;
      if (Hi !== exp_hi || Lo !== exp_lo) hold_ok = 0;
    end
    check({tag, "_busy_window"}, busy_ok, 1);
    check({tag, "_hilo_hold"}, hold_ok, 1);
    check({tag, "_early_done"}, done_cnt, 0);
    @(posedge Clk); #1;  // E33
    check({tag, "_done"}, Done, 1);
    check({tag, "_busy_after"}, Busy, 0);
    check({tag, "_hi"}, Hi, nh);
    check({tag, "_lo"}, Lo, nl);
    exp_hi = nh; exp_lo = nl;
    @(posedge Clk); #1;
    check({tag, "_done_pulse"}, Done, 0);
  endtask

  task automatic move_to(input bit hw, input bit lw, input logic [31:0] val, input string tag);
    @(negedge Clk);
    HiWrite = hw; LoWrite = lw; A = val;
    @(posedge Clk); #1;
    HiWrite = 1'b0; LoWrite = 1'b0;
    if (hw) exp_hi = val;
    if (lw) exp_lo = val;
    check({tag, "_hi"}, Hi, exp_hi);
    check({tag, "_lo"}, Lo, exp_lo);
    check({tag, "_busy"}, Busy, 0);
    check({tag, "_done"}, Done, 0);
  endtask

  initial begin
    int quiet;
    logic [31:0] ra, rb;
    logic [1:0]  rop;

    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", {Hi, Lo, Busy, Done}, 66'd0);
    @(negedge Clk);
    Rst = 1'b1;

    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, 0, 0, "mult_neg3x7");
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, "multu_max");
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, 0, "div_neg7by2");
    run_op(2'd3, 32'h0000_1234, 32'd0, 0, 0, "divu_by0");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div_ovf");
    run_op(2'd2, 32'h8000_0005, 32'd0, 0, 0, "div_neg_by0");
    run_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0, "multu_disturb");
    run_op(2'd0, 32'h7FFF_FFFF, 32'h8000_0000, 0, 1, "mult_start_write");
    move_to(1'b0, 1'b1, 32'hCAFE_0000, "mtlo");
    move_to(1'b1, 1'b0, 32'h0BAD_F00D, "mthi");

    // Asynchronous reset in the middle of CALC discards the operation.
    @(negedge Clk);
    Start = 1'b1; Op = 2'd1; A = 32'hDEAD_BEEF; B = 32'h1111_1111;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (14) @(posedge Clk);
    #3;
    Rst = 1'b0;
    #1;
    check("rst_mid_calc", {Hi, Lo, Busy, Done}, 66'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    @(negedge Clk);
    Rst = 1'b1;
    quiet = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk); #1;
      if (Done || Busy) quiet++;
    end
    check("rst_no_done", quiet, 0);
    run_op(2'd0, 32'd6, 32'd7, 0, 0, "mult_6x7");

    for (int i = 0; i < 24; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 16));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0),
             $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
